counter_chain_sequencer: RTL and testbench
==========================================

# counter_chain_sequencer

Synchronous controller that exercises the asynchronous counter pipeline, the chain of STAGES toggle stages joined by four-phase ri/ai and ro/ao handshakes. It issues a programmed number of input handshakes on the ri/ai side and acts as the environment on the ro/ao side. It counts completed output handshakes and flags protocol or liveness faults. It sits between the clocked test/control logic and the self-timed counter netlist and is the only clocked agent touching those four wires.

## Interface
Parameters:
- STAGES, 4, number of counter stages; one output handshake is expected per 2^STAGES input handshakes.
- CNT_W, 16, width of token and event counters.
- SYNC_STAGES, 2, flops in each synchronizer on ai and ro (minimum 2).
- TIMEOUT, 255, maximum cycles spent in any single wait before error.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  run command, sampled only in IDLE.
- n_tokens  in  CNT_W  number of input handshakes to issue, captured on start.
- busy  out  1  high from start acceptance until done/error.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky fault flag, cleared by next accepted start or reset.
- in_count  out  CNT_W  completed input handshakes in the current run.
- out_count  out  CNT_W  completed output handshakes in the current run.
- ri  out  1  request into counter chain, registered.
- ai  in  1  acknowledge from chain, asynchronous.
- ro  in  1  request out of chain, asynchronous.
- ao  out  1  acknowledge to chain, registered.

## Operation
- Reset: state IDLE; ri=0, ao=0, busy=0, done=0, error=0, in_count=0, out_count=0; synchronizers cleared to 0.
- ai_s and ro_s are the SYNC_STAGES-flop synchronized versions of ai and ro; no logic uses raw ai/ro.
- Input FSM states: IDLE, RISE, FALL, DRAIN, ERR.
  - IDLE: start=1 captures n_tokens, clears counters and error, sets busy. If n_tokens=0, go to DRAIN; else go to RISE.
  - RISE: ri=1; when ai_s=1, go to FALL.
  - FALL: ri=0; when ai_s=0, increment in_count. If in_count+1 = n_tokens, go to DRAIN; else go to RISE.
  - DRAIN: ri=0. Wait until out_count = n_tokens >> STAGES, ro_s=0 and ao=0. Then pulse done, clear busy and go to IDLE.
  - ERR: ri=0, error=1, busy=0. Go to IDLE on the next cycle. The ao responder keeps running so the chain can settle.
- Output responder, independent of the FSM and active in every state:
  - ao is registered from ro_s each cycle.
  - out_count increments on the cycle ao falls (ao=1, ro_s=0).
- Faults, each of which enters ERR on the cycle it is detected:
  - wait timer in RISE, FALL or DRAIN exceeds TIMEOUT; the timer restarts on every state change;
  - out_count would exceed n_tokens >> STAGES;
  - ro_s rises while in IDLE with out_count already at expected value (spurious output).
- start while busy is ignored. Start in the same cycle as a done pulse is ignored; a new run starts no earlier than the cycle after the return to IDLE.
- Counters wrap modulo 2^CNT_W. n_tokens = 2^CNT_W−1 is legal.
- n_tokens not a multiple of 2^STAGES: the remainder leaves the chain in a non-initial state. This is legal, and the expected output count uses floor division.
- Reset mid-run: all outputs return to reset values immediately, including ri=0 and ao=0 with no handshake completion. The chain must also be reset externally.

## Timing
- start sampled at edge k; ri=1 and busy=1 after edge k.
- ai rise to RISE→FALL transition takes SYNC_STAGES+1 edges; ri falls on that edge. FALL→RISE behaves the same.
- Minimum input handshake period, with an instantaneous chain: 2·(SYNC_STAGES+1) cycles; 6 at defaults.
- ro rise to ao rise: SYNC_STAGES+1 edges; ro fall to ao fall likewise.
- done asserts the edge after the DRAIN exit condition is met, for exactly one cycle.
- The error flag is visible the edge after the fault is detected.

## Test plan
- Ideal chain model (ai=ri after 1 cycle; ro toggles per 16 inputs), STAGES=4, n_tokens=32 -> in_count=32, out_count=2, single done pulse, error=0, ri=ao=0 at end.
- n_tokens=0 -> done pulses 2 cycles after start, in_count=out_count=0, ri never rises.
- ai stuck at 0 after start -> error=1 at cycle TIMEOUT+2 after entering RISE, busy=0, ri=0.
- Chain model emits 3 output handshakes for n_tokens=32 -> error on the third ao falling edge; out_count=3 shown.
- rst_n pulsed low mid-run after 10 tokens -> ri=0, ao=0, counters 0 immediately. A subsequent start with n_tokens=16 completes with out_count=1.
- start held high throughout a run of n_tokens=17 -> only one run executes; out_count=1, in_count=17. The second run begins only after done.

Source files
------------

// File: rtl/counter_chain_sequencer.sv
// Clocked driver/responder for the self-timed counter chain: issues n_tokens
// four-phase input handshakes on ri/ai, answers ro/ao, and flags faults.
module counter_chain_sequencer #(
  parameter int unsigned STAGES      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_tokens,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] in_count,
  output logic [CNT_W-1:0] out_count,
  output logic             ri,
  input  logic             ai,
  input  logic             ro,
  output logic             ao
);

  localparam int unsigned       TMR_W     = $clog2(TIMEOUT + 2);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RISE,
    S_FALL,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_ai_sync;
  logic [SYNC_STAGES-1:0] r_ro_sync;
  logic [CNT_W-1:0]       r_n_tokens;
  logic [CNT_W-1:0]       r_in_count;
  logic [CNT_W-1:0]       r_out_count;
  logic [TMR_W-1:0]       r_timer;
  logic                   r_ri;
  logic                   r_ao;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  logic             w_ai_s;
  logic             w_ro_s;
  logic [CNT_W-1:0] w_expected;
  logic [CNT_W-1:0] w_in_inc;
  logic             w_ao_fall;
  logic             w_overflow;
  logic             w_timeout;
  logic             w_fault;
  logic             w_accept;
  logic             w_inc_in;
  logic             w_exit;
  logic             w_timer_clr;

  assign w_ai_s      = r_ai_sync[SYNC_STAGES-1];
  assign w_ro_s      = r_ro_sync[SYNC_STAGES-1];
  assign w_expected  = r_n_tokens >> STAGES;
  assign w_in_inc    = r_in_count + CNT_W'(1);
  // ao is ro_s delayed by one cycle, so it doubles as the ro_s edge reference
  assign w_ao_fall   = r_ao & ~w_ro_s;
  assign w_overflow  = w_ao_fall && (r_out_count == w_expected);
  assign w_timeout   = r_timer > TMR_LIMIT;
  assign w_fault     = w_timeout || w_overflow;
  assign w_timer_clr = (w_next != r_state) || (r_state == S_IDLE) || (r_state == S_ERR);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_inc_in = 1'b0;
    w_exit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !r_done) begin
          w_accept = 1'b1;
          w_next   = (n_tokens == '0) ? S_DRAIN : S_RISE;
        end else if (w_ro_s && !r_ao && (r_out_count == w_expected)) begin
          w_next = S_ERR;
        end
      end
      S_RISE: begin
        if (w_fault)     w_next = S_ERR;
        else if (w_ai_s) w_next = S_FALL;
      end
      S_FALL: begin
        if (w_fault) begin
          w_next = S_ERR;
        end else if (!w_ai_s) begin
          w_inc_in = 1'b1;
          w_next   = (w_in_inc == r_n_tokens) ? S_DRAIN : S_RISE;
        end
      end
      S_DRAIN: begin
        if (w_fault) begin
          w_next = S_ERR;
        end else if ((r_out_count == w_expected) && !w_ro_s && !r_ao) begin
          w_exit = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ai_sync   <= '0;
      r_ro_sync   <= '0;
      r_n_tokens  <= '0;
      r_in_count  <= '0;
      r_out_count <= '0;
      r_timer     <= '0;
      r_ri        <= 1'b0;
      r_ao        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_ai_sync <= {r_ai_sync[SYNC_STAGES-2:0], ai};
      r_ro_sync <= {r_ro_sync[SYNC_STAGES-2:0], ro};
      r_state   <= w_next;
      r_timer   <= w_timer_clr ? '0 : r_timer + TMR_W'(1);
      r_ri      <= (w_next == S_RISE);
      r_ao      <= w_ro_s;
      r_done    <= w_exit;
      if (w_accept) begin
        r_n_tokens  <= n_tokens;
        r_in_count  <= '0;
        r_out_count <= '0;
        r_error     <= 1'b0;
        r_busy      <= 1'b1;
      end else begin
        if (w_inc_in)  r_in_count  <= w_in_inc;
        if (w_ao_fall) r_out_count <= r_out_count + CNT_W'(1);
        if ((w_next == S_ERR) && (r_state != S_ERR)) begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
        end
        if (w_exit) r_busy <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign in_count  = r_in_count;
  assign out_count = r_out_count;
  assign ri        = r_ri;
  assign ao        = r_ao;

endmodule

// File: tb/tb_counter_chain_sequencer.sv
// Directed bench for counter_chain_sequencer with a behavioural 4-stage
// counter chain model (ai follows ri, one ro/ao handshake per 16 inputs).
module tb_counter_chain_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] n_tokens;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] in_count;
  logic [15:0] out_count;
  logic        ri;
  logic        ai = 1'b0;
  logic        ro = 1'b0;
  logic        ao;

  int tests = 0;
  int fails = 0;

  bit m_clr      = 1'b1;
  bit m_ai_stuck = 1'b0;
  int m_preload  = 0;
  int m_cnt      = 0;
  int m_pending  = 0;
  bit m_ai_q     = 1'b0;

  counter_chain_sequencer #(
    .STAGES(4),
    .CNT_W(16),
    .SYNC_STAGES(2),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .n_tokens(n_tokens),
    .busy(busy),
    .done(done),
    .error(error),
    .in_count(in_count),
    .out_count(out_count),
    .ri(ri),
    .ai(ai),
    .ro(ro),
    .ao(ao)
  );

  always #5 clk = ~clk;

  // Chain model acts on the falling edge, away from the DUT's sampling edge.
  always @(negedge clk) begin
    if (m_clr) begin
      m_cnt     = 0;
      m_pending = m_preload;
      m_ai_q    = 1'b0;
      ai        = 1'b0;
      ro        = 1'b0;
    end else begin
      ai = m_ai_stuck ? 1'b0 : ri;
      if (m_ai_q && !ai) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == 16) begin
          m_cnt     = 0;
          m_pending = m_pending + 1;
        end
      end
      m_ai_q = ai;
      if (ro && ao) begin
        ro = 1'b0;
      end else if (!ro && !ao && m_pending > 0) begin
        ro        = 1'b1;
        m_pending = m_pending - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] n);
    n_tokens = n;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_for(input int sel, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #1;
      case (sel)
        0:       hit = done;
        1:       hit = error;
        default: hit = (in_count == 16'd10);
      endcase
    end
  endtask

  task automatic clear_model();
    m_clr = 1'b1;
    @(posedge clk); #1;
    m_clr = 1'b0;
  endtask

  initial begin
    bit hit;
    rst_n    = 1'b0;
    start    = 1'b0;
    n_tokens = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ri",   32'(ri), 0);
    chk("rst_ao",   32'(ao), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err",  32'(error), 0);
    chk("rst_in",   32'(in_count), 0);
    chk("rst_out",  32'(out_count), 0);
    rst_n = 1'b1;
    m_clr = 1'b0;
    @(posedge clk); #1;

    // Ideal chain, 32 tokens -> 2 output handshakes
    start_run(16'd32);
    chk("t32_busy", 32'(busy), 1);
    chk("t32_ri",   32'(ri), 1);
    wait_for(0, 1000, hit);
    chk("t32_done_seen", 32'(hit), 1);
    chk("t32_in",   32'(in_count), 32);
    chk("t32_out",  32'(out_count), 2);
    chk("t32_err",  32'(error), 0);
    chk("t32_ri_end", 32'(ri), 0);
    chk("t32_ao_end", 32'(ao), 0);
    chk("t32_busy_end", 32'(busy), 0);
    @(posedge clk); #1;
    chk("t32_done_pulse", 32'(done), 0);

    // Zero tokens: straight to DRAIN, done two edges after start is driven
    start_run(16'd0);
    chk("t0_busy", 32'(busy), 1);
    chk("t0_done_early", 32'(done), 0);
    chk("t0_ri", 32'(ri), 0);
    @(posedge clk); #1;
    chk("t0_done", 32'(done), 1);
    chk("t0_in",  32'(in_count), 0);
    chk("t0_out", 32'(out_count), 0);
    chk("t0_ri2", 32'(ri), 0);
    @(posedge clk); #1;
    chk("t0_done_pulse", 32'(done), 0);

    // ai stuck low: RISE times out, error on the 257th edge after entry
    m_ai_stuck = 1'b1;
    start_run(16'd5);
    repeat (256) @(posedge clk);
    #1;
    chk("stuck_err_early", 32'(error), 0);
    chk("stuck_ri_held",   32'(ri), 1);
    @(posedge clk); #1;
    chk("stuck_err",  32'(error), 1);
    chk("stuck_busy", 32'(busy), 0);
    chk("stuck_ri",   32'(ri), 0);
    m_ai_stuck = 1'b0;
    @(posedge clk); #1;

    // Chain emits one extra output handshake -> overflow on the third ao fall
    m_preload = 1;
    clear_model();
    start_run(16'd32);
    chk("extra_err_clr", 32'(error), 0);
    wait_for(1, 1000, hit);
    chk("extra_err_seen", 32'(hit), 1);
    chk("extra_out",  32'(out_count), 3);
    chk("extra_busy", 32'(busy), 0);
    chk("extra_in",   32'(in_count), 32);
    m_preload = 0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a run
    clear_model();
    start_run(16'd32);
    chk("mid_err_clr", 32'(error), 0);
    wait_for(2, 500, hit);
    chk("mid_ten_seen", 32'(hit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_ri",   32'(ri), 0);
    chk("mid_ao",   32'(ao), 0);
    chk("mid_in",   32'(in_count), 0);
    chk("mid_out",  32'(out_count), 0);
    chk("mid_busy", 32'(busy), 0);
    m_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_clr = 1'b0;
    @(posedge clk); #1;
    start_run(16'd16);
    wait_for(0, 1000, hit);
    chk("post_rst_done_seen", 32'(hit), 1);
    chk("post_rst_out", 32'(out_count), 1);
    chk("post_rst_in",  32'(in_count), 16);
    chk("post_rst_err", 32'(error), 0);

    // start held high: the run completes before a second one is accepted
    @(posedge clk); #1;
    clear_model();
    n_tokens = 16'd17;
    start    = 1'b1;
    wait_for(0, 1000, hit);
    chk("held_done_seen", 32'(hit), 1);
    chk("held_in",   32'(in_count), 17);
    chk("held_out",  32'(out_count), 1);
    chk("held_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("held_ignored_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("held_restart_busy", 32'(busy), 1);
    chk("held_restart_in",   32'(in_count), 0);
    start = 1'b0;
    wait_for(0, 1000, hit);
    chk("held2_done_seen", 32'(hit), 1);
    chk("held2_in",  32'(in_count), 17);
    chk("held2_out", 32'(out_count), 1);
    chk("held2_err", 32'(error), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
